apb_crc_master: RTL
===================

// Module: apb_crc_master
// PURPOSE
//  APB master that sits directly upstream of the APB CRC-8 peripheral.
//  - Accepts a byte stream on a valid/ready port.
//  - Writes each byte to the peripheral's data register (offset 0x0).
//  - After the byte flagged last, reads the CRC register (offset 0x4) and
//    presents the result with a one-cycle valid strobe.
//  - Slave stalls are bounded by a timeout, so the pipeline never hangs.
// PARAMETERS
//  BASE_ADDR  32'h0000_0000  peripheral base; data at BASE_ADDR+0, CRC at BASE_ADDR+4
//  TIMEOUT    16             max ACCESS cycles waiting for p_ready_i (>=2)
//  TO_W       $clog2(TIMEOUT+1)  timeout counter width
// PORTS
//  p_clk_i      in   1   clock; all logic on rising edge
//  p_rstn_i     in   1   reset, asynchronous, active-low
//  s_data_i     in   8   stream byte
//  s_valid_i    in   1   stream byte valid
//  s_last_i     in   1   byte is final byte of packet
//  s_ready_o    out  1   master can accept a byte
//  crc_o        out  8   CRC read back for last packet
//  crc_valid_o  out  1   one-cycle strobe: crc_o updated
//  err_o        out  1   one-cycle strobe: transfer aborted (timeout/slverr)
//  p_adr_o      out  32  APB address
//  p_dat_o      out  32  APB write data
//  p_dat_i      in   32  APB read data
//  p_sel_o      out  1   APB select
//  p_enable_o   out  1   APB enable
//  p_we_o       out  1   APB write (1) / read (0)
//  p_ready_i    in   1   APB ready from slave
//  p_slverr_i   in   1   APB error, sampled with p_ready_i
// BEHAVIOUR
//  Reset:
//  - While p_rstn_i=0, every output and register is 0 and FSM is in IDLE.
//  - Reset asserted in any state aborts immediately.
//  - No err_o or crc_valid_o is generated for the aborted transfer.
//  Registers: all APB outputs are registered; s_ready_o is registered and equals 1 exactly while in IDLE.
//  FSM states: IDLE, WSETUP, WACCESS, RSETUP, RACCESS, DONE, ERR.
//  - IDLE: s_valid_i & s_ready_o captures byte and last flag; next state WSETUP.
//  - WSETUP (1 cycle):
//    - sel=1, enable=0, we=1, adr=BASE_ADDR, dat={24'h0,byte}.
//    - Next state WACCESS.
//  - WACCESS: sel=1, enable=1; adr/dat/we held stable until p_ready_i.
//    - p_ready_i & ~p_slverr_i & last  -> RSETUP.
//    - p_ready_i & ~p_slverr_i & ~last -> IDLE.
//    - p_ready_i & p_slverr_i -> ERR.
//  - RSETUP (1 cycle): sel=1, enable=0, we=0, adr=BASE_ADDR+4, dat=0.
//  - RACCESS: sel=1, enable=1 until p_ready_i.
//    - Capture read data (see CONFIGURATION).
//    - No slverr -> DONE; slverr -> ERR.
//  - DONE (1 cycle): crc_o <= captured[7:0]; crc_valid_o=1; next state IDLE.
//  - ERR (1 cycle): err_o=1; crc_o unchanged; next state IDLE.
//  Handshake and timeout:
//  - sel/enable drop to 0 in the cycle after p_ready_i is sampled high.
//  - Timeout counter clears on entry to each ACCESS state and increments every ACCESS cycle without p_ready_i.
//  - When the count reaches TIMEOUT: sel/enable drop and FSM goes to ERR.
//  - p_ready_i arriving in the same cycle the count hits TIMEOUT counts as success (ready wins).
//  Signal rules:
//  - p_ready_i/p_slverr_i are ignored outside ACCESS states.
//  - s_valid_i is ignored outside IDLE.
//  - After ERR, the remaining bytes of the packet are still accepted as normal writes.
//  Latency and throughput:
//  - Minimum 3 cycles per byte: IDLE, WSETUP, WACCESS with immediate ready.
//  - Minimum +3 cycles for the CRC read.
// CONFIGURATION
//  Macro RDATA_OR_CAPTURE_EN:
//  - Defined: read capture register clears at RSETUP and ORs in p_dat_i every RACCESS cycle. This supports slaves that
//    drive read data as a single-cycle strobe during ACCESS and 0 otherwise.
//  - Undefined: p_dat_i is sampled only in the RACCESS cycle where p_ready_i=1 (standard APB).
// TESTING
//  1. Single byte 0x5A, last=1; slave ready after 3 cycles, rdata=0xA5 at ready
//     -> one write (adr=BASE, dat=0x5A), one read (adr=BASE+4); crc_o=0xA5 with one-cycle crc_valid_o.
//  2. Packet 0x11,0x22,0x33 (last on 0x33), s_valid_i held high
//     -> three writes in order, s_ready_o low during each transfer, exactly one read afterwards.
//  3. Slave never asserts p_ready_i
//     -> after TIMEOUT=16 ACCESS cycles: sel/enable drop, err_o pulses once, crc_valid_o stays 0, s_ready_o returns to 1.
//  4. p_slverr_i=1 with ready on write of a last byte
//     -> err_o pulse, no read issued, crc_o keeps previous value.
//  5. p_rstn_i low in 2nd WACCESS cycle
//     -> all outputs 0 during reset; after release s_ready_o=1 with no stray strobes.
//  6. Slave drives rdata=0x3C only in the 2nd RACCESS cycle, 0 at ready
//     -> crc_o=0x3C with RDATA_OR_CAPTURE_EN, crc_o=0x00 without.

Source files
------------

// File: rtl/apb_crc_master.sv
// APB master feeding an APB CRC-8 peripheral: writes each stream byte to BASE_ADDR+0 and,
// after the byte flagged last, reads the CRC at BASE_ADDR+4. Optional macro: RDATA_OR_CAPTURE_EN.
module apb_crc_master #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned TO_W      = $clog2(TIMEOUT + 1)
) (
    input  logic        p_clk_i,
    input  logic        p_rstn_i,
    input  logic [7:0]  s_data_i,
    input  logic        s_valid_i,
    input  logic        s_last_i,
    output logic        s_ready_o,
    output logic [7:0]  crc_o,
    output logic        crc_valid_o,
    output logic        err_o,
    output logic [31:0] p_adr_o,
    output logic [31:0] p_dat_o,
    input  logic [31:0] p_dat_i,
    output logic        p_sel_o,
    output logic        p_enable_o,
    output logic        p_we_o,
    input  logic        p_ready_i,
    input  logic        p_slverr_i
);

    typedef enum logic [2:0] {
        IDLE,
        WSETUP,
        WACCESS,
        RSETUP,
        RACCESS,
        DONE,
        ERR
    } state_e;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            last_q, last_d;
    logic [7:0]      crc_q, crc_d;
    logic            crc_valid_q, crc_valid_d;
    logic            err_q, err_d;
    logic            s_ready_q, s_ready_d;
    logic [31:0]     adr_q, adr_d;
    logic [31:0]     dat_q, dat_d;
    logic            sel_q, sel_d;
    logic            en_q, en_d;
    logic            we_q, we_d;
    logic [7:0]      rcap;
    logic            timed_out;

`ifdef RDATA_OR_CAPTURE_EN
    logic [7:0]      rdata_q, rdata_d;
`endif

    // Only the low byte of the read word carries the CRC.
    logic unused_rdata_hi;
    assign unused_rdata_hi = ^p_dat_i[31:8];

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d = state_q;
        to_d    = to_q;
        last_d  = last_q;
        crc_d   = crc_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        we_d    = we_q;
`ifdef RDATA_OR_CAPTURE_EN
        rdata_d = rdata_q;
        rcap    = rdata_q | p_dat_i[7:0];
`else
        rcap    = p_dat_i[7:0];
`endif
        timed_out = (to_q == TO_LAST);

        unique case (state_q)
            IDLE: begin
                if (s_valid_i && s_ready_q) begin
                    state_d = WSETUP;
                    last_d  = s_last_i;
                    adr_d   = BASE_ADDR;
                    dat_d   = {24'h0, s_data_i};
                    we_d    = 1'b1;
                end
            end
            WSETUP: begin
                state_d = WACCESS;
                to_d    = '0;
            end
            WACCESS: begin
                // A ready in the final allowed cycle still completes the transfer.
                if (p_ready_i) begin
                    if (p_slverr_i) begin
                        state_d = ERR;
                    end else if (last_q) begin
                        state_d = RSETUP;
                        adr_d   = BASE_ADDR + 32'd4;
                        dat_d   = 32'h0;
                        we_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (timed_out) begin
                    state_d = ERR;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            RSETUP: begin
                state_d = RACCESS;
                to_d    = '0;
`ifdef RDATA_OR_CAPTURE_EN
                rdata_d = 8'h0;
`endif
            end
            RACCESS: begin
`ifdef RDATA_OR_CAPTURE_EN
                rdata_d = rcap;
`endif
                if (p_ready_i) begin
                    if (p_slverr_i) begin
                        state_d = ERR;
                    end else begin
                        state_d = DONE;
                        crc_d   = rcap;
                    end
                end else if (timed_out) begin
                    state_d = ERR;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with state_q.
        sel_d       = (state_d inside {WSETUP, WACCESS, RSETUP, RACCESS});
        en_d        = (state_d inside {WACCESS, RACCESS});
        s_ready_d   = (state_d == IDLE);
        crc_valid_d = (state_d == DONE);
        err_d       = (state_d == ERR);
    end

    always_ff @(posedge p_clk_i or negedge p_rstn_i) begin
        if (!p_rstn_i) begin
            state_q     <= IDLE;
            to_q        <= '0;
            last_q      <= 1'b0;
            crc_q       <= 8'h0;
            crc_valid_q <= 1'b0;
            err_q       <= 1'b0;
            s_ready_q   <= 1'b0;
            adr_q       <= 32'h0;
            dat_q       <= 32'h0;
            sel_q       <= 1'b0;
            en_q        <= 1'b0;
            we_q        <= 1'b0;
`ifdef RDATA_OR_CAPTURE_EN
            rdata_q     <= 8'h0;
`endif
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            state_q     <= state_d;
            to_q        <= to_d;
            last_q      <= last_d;
            crc_q       <= crc_d;
            crc_valid_q <= crc_valid_d;
            err_q       <= err_d;
            s_ready_q   <= s_ready_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            en_q        <= en_d;
            we_q        <= we_d;
`ifdef RDATA_OR_CAPTURE_EN
            rdata_q     <= rdata_d;
`endif
        end
    end

    assign s_ready_o   = s_ready_q;
    assign crc_o       = crc_q;
    assign crc_valid_o = crc_valid_q;
    assign err_o       = err_q;
    assign p_adr_o     = adr_q;
    assign p_dat_o     = dat_q;
    assign p_sel_o     = sel_q;
    assign p_enable_o  = en_q;
    assign p_we_o      = we_q;

    // Protocol invariants of the master side.
    a_enable_needs_sel: assert property (@(posedge p_clk_i) disable iff (!p_rstn_i)
        p_enable_o |-> p_sel_o);
    a_setup_then_access: assert property (@(posedge p_clk_i) disable iff (!p_rstn_i)
        (p_sel_o && !p_enable_o) |=> p_enable_o);
    a_access_stable: assert property (@(posedge p_clk_i) disable iff (!p_rstn_i)
        (p_sel_o && p_enable_o && !p_ready_i) |=>
            ($stable(p_adr_o) && $stable(p_dat_o) && $stable(p_we_o)));
    a_strobes_exclusive: assert property (@(posedge p_clk_i) disable iff (!p_rstn_i)
        !(crc_valid_o && err_o));
    a_crc_one_cycle: assert property (@(posedge p_clk_i) disable iff (!p_rstn_i)
        crc_valid_o |=> !crc_valid_o);
    a_err_one_cycle: assert property (@(posedge p_clk_i) disable iff (!p_rstn_i)
        err_o |=> !err_o);

endmodule
